// File: rtl/transform_streamer_if.sv
// Output beat stream of the transform streamer: one {lhs, rhs} character pair per beat.
// The master drives the beat and holds it until the slave accepts it with out_ready.
interface transform_streamer_if #(
  parameter int CHAR_W = 8
) ();
  logic              out_valid;
  logic              out_ready;
  logic [CHAR_W-1:0] out_lhs;
  logic [CHAR_W-1:0] out_rhs;
  logic              out_last;

  modport master (
    output out_valid,
    output out_lhs,
    output out_rhs,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_lhs,
    input  out_rhs,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/transform_streamer.sv
// Looks up a {len, base} line descriptor, then walks the character-pair memory from base
// for len entries, emitting each pair (optionally swapped) as one beat on the output stream.
module transform_streamer #(
  parameter int CHAR_W = 8,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 6,
  parameter int LINE_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LINE_W-1:0]       line,
  input  logic                    swap,
  output logic [LINE_W-1:0]       ptr_line,
  input  logic [LEN_W+ADDR_W-1:0] ptr_data,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [2*CHAR_W-1:0]     mem_dout,
  transform_streamer_if.master    stream,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FETCH,
    CAPTURE,
    OUT,
    DONE
  } state_t;

  state_t             state;
  logic               swap_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   count;

  logic [LEN_W-1:0]   desc_len;
  logic [ADDR_W-1:0]  desc_base;
  logic [CHAR_W-1:0]  mem_lhs;
  logic [CHAR_W-1:0]  mem_rhs;

  assign desc_len  = ptr_data[LEN_W+ADDR_W-1:ADDR_W];
  assign desc_base = ptr_data[ADDR_W-1:0];
  assign mem_lhs   = mem_dout[2*CHAR_W-1:CHAR_W];
  assign mem_rhs   = mem_dout[CHAR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      swap_q           <= 1'b0;
      len_q            <= '0;
      count            <= '0;
      ptr_line         <= '0;
      mem_addr         <= '1;
      stream.out_valid <= 1'b0;
      stream.out_lhs   <= '0;
      stream.out_rhs   <= '0;
      stream.out_last  <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // All-ones is the blank address while no walk is in progress.
          mem_addr <= '1;
          if (start) begin
            ptr_line <= line;
            swap_q   <= swap;
            busy     <= 1'b1;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          len_q <= desc_len;
          count <= '0;
          if (desc_len == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            mem_addr <= desc_base;
            state    <= FETCH;
          end
        end
        FETCH: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          stream.out_lhs   <= swap_q ? mem_rhs : mem_lhs;
          stream.out_rhs   <= swap_q ? mem_lhs : mem_rhs;
          stream.out_last  <= (count == len_q - LEN_W'(1));
          stream.out_valid <= 1'b1;
          state            <= OUT;
        end
        OUT: begin
          if (stream.out_ready) begin
            stream.out_valid <= 1'b0;
            if (stream.out_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // Address wraps modulo 2^ADDR_W by design.
              mem_addr <= mem_addr + ADDR_W'(1);
              count    <= count + LEN_W'(1);
              state    <= FETCH;
            end
          end
        end
        DONE: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          mem_addr <= '1;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transform_streamer.sv
// Directed-vector bench for transform_streamer: pointer table and registered-read character
// memory are modelled here; each scenario task checks its own hand-computed expectations.
module tb_transform_streamer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  line;
  logic        swap;
  logic [5:0]  ptr_line;
  logic [13:0] ptr_data;
  logic [7:0]  mem_addr;
  logic [15:0] mem_dout;
  logic        busy;
  logic        done;

  transform_streamer_if #(.CHAR_W(8)) stream ();

  transform_streamer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .line     (line),
    .swap     (swap),
    .ptr_line (ptr_line),
    .ptr_data (ptr_data),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .stream   (stream),
    .busy     (busy),
    .done     (done)
  );

  logic [15:0] mem  [256];
  logic [13:0] ptab [64];

  assign ptr_data = ptab[ptr_line];
  always @(posedge clk) mem_dout <= mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Results of the most recent walk.
  logic [7:0] q_lhs [$];
  logic [7:0] q_rhs [$];
  logic       q_last[$];
  logic [7:0] q_addr[$];
  int  done_cnt, done_k;
  logic busy_e0, busy_end, done_end;
  bit  unstable, dropped, valid_seen, addr_moved, timed_out;

  // Must be entered #1 after a rising edge; start is sampled on the next edge (E0).
  // Returns one cycle after done, i.e. on the first IDLE cycle.
  task automatic run_walk(input logic [5:0] l, input logic sw, input int stall);
    logic [7:0] pl, pr;
    logic plast, pv, pready;
    int hold;
    q_lhs.delete(); q_rhs.delete(); q_last.delete(); q_addr.delete();
    done_cnt = 0; done_k = -1; unstable = 0; dropped = 0;
    valid_seen = 0; addr_moved = 0; timed_out = 0;
    stream.out_ready = (stall == 0);
    start = 1'b1; line = l; swap = sw;
    @(posedge clk); #1;
    start = 1'b0; line = 6'($urandom); swap = ~sw;
    busy_e0 = busy;
    pv = 1'b0; pready = 1'b0; pl = '0; pr = '0; plast = 1'b0; hold = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (mem_addr !== 8'hFF) addr_moved = 1;
      if (pv && !pready) begin
        if (!stream.out_valid) dropped = 1;
        else if ({stream.out_lhs, stream.out_rhs, stream.out_last} !== {pl, pr, plast}) unstable = 1;
      end
      if (stream.out_valid) begin
        valid_seen = 1;
        if (hold < stall) begin
          stream.out_ready = 1'b0;
          hold++;
        end else begin
          stream.out_ready = 1'b1;
          hold = 0;
          q_lhs.push_back(stream.out_lhs);
          q_rhs.push_back(stream.out_rhs);
          q_last.push_back(stream.out_last);
          q_addr.push_back(mem_addr);
        end
      end else begin
        stream.out_ready = (stall == 0);
      end
      pv = stream.out_valid; pready = stream.out_ready;
      pl = stream.out_lhs; pr = stream.out_rhs; plast = stream.out_last;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k > done_k) begin
        busy_end = busy;
        done_end = done;
        break;
      end
    end
    if (done_k < 0) timed_out = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; line = '0; swap = 1'b0; stream.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (stream.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", stream.out_valid); end
    n_cmp++; if (stream.out_last !== 1'b0) begin n_err++; $display("FAIL reset_last got %b exp 0", stream.out_last); end
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_busy_done got %b exp 00", {busy, done}); end
    n_cmp++; if ({stream.out_lhs, stream.out_rhs} !== 16'h0000) begin n_err++; $display("FAIL reset_chars got %h exp 0000", {stream.out_lhs, stream.out_rhs}); end
    n_cmp++; if (ptr_line !== 6'd0) begin n_err++; $display("FAIL reset_ptr_line got %0d exp 0", ptr_line); end
    n_cmp++; if (mem_addr !== 8'hFF) begin n_err++; $display("FAIL reset_mem_addr got %h exp ff", mem_addr); end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: busy=%b done=%b mem_addr=%h", busy, done, mem_addr);
  endtask

  task automatic test_basic();
    run_walk(6'd0, 1'b0, 0);
    $display("basic: beats=%0d done_k=%0d done_cnt=%0d", q_lhs.size(), done_k, done_cnt);
    n_cmp++; if (timed_out) begin n_err++; $display("FAIL basic_timeout got no done exp done"); end
    n_cmp++; if (q_lhs.size() != 3) begin n_err++; $display("FAIL basic_count got %0d exp 3", q_lhs.size()); end
    if (q_lhs.size() == 3) begin
      n_cmp++; if ({q_lhs[0], q_rhs[0], q_last[0]} !== {8'h31, 8'h31, 1'b0}) begin n_err++; $display("FAIL basic_beat0 got %h %h %b exp 31 31 0", q_lhs[0], q_rhs[0], q_last[0]); end
      n_cmp++; if ({q_lhs[1], q_rhs[1], q_last[1]} !== {8'h41, 8'h42, 1'b0}) begin n_err++; $display("FAIL basic_beat1 got %h %h %b exp 41 42 0", q_lhs[1], q_rhs[1], q_last[1]); end
      n_cmp++; if ({q_lhs[2], q_rhs[2], q_last[2]} !== {8'h43, 8'h44, 1'b1}) begin n_err++; $display("FAIL basic_beat2 got %h %h %b exp 43 44 1", q_lhs[2], q_rhs[2], q_last[2]); end
    end
    n_cmp++; if (busy_e0 !== 1'b1) begin n_err++; $display("FAIL basic_busy_rise got %b exp 1", busy_e0); end
    n_cmp++; if (done_k != 10) begin n_err++; $display("FAIL basic_done_latency got %0d exp 10", done_k); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL basic_done_pulses got %0d exp 1", done_cnt); end
    n_cmp++; if ({busy_end, done_end} !== 2'b00) begin n_err++; $display("FAIL basic_end_busy_done got %b exp 00", {busy_end, done_end}); end
    n_cmp++; if (mem_addr !== 8'hFF) begin n_err++; $display("FAIL basic_end_addr got %h exp ff", mem_addr); end
  endtask

  task automatic test_backpressure();
    run_walk(6'd0, 1'b0, 5);
    $display("backpressure: beats=%0d unstable=%0d dropped=%0d", q_lhs.size(), unstable, dropped);
    n_cmp++; if (timed_out) begin n_err++; $display("FAIL bp_timeout got no done exp done"); end
    n_cmp++; if (q_lhs.size() != 3) begin n_err++; $display("FAIL bp_count got %0d exp 3", q_lhs.size()); end
    n_cmp++; if (unstable || dropped) begin n_err++; $display("FAIL bp_hold got unstable=%0d dropped=%0d exp 0 0", unstable, dropped); end
    if (q_lhs.size() == 3) begin
      n_cmp++; if ({q_lhs[1], q_rhs[1], q_lhs[2], q_rhs[2], q_last[2]} !== {8'h41, 8'h42, 8'h43, 8'h44, 1'b1}) begin
        n_err++; $display("FAIL bp_beats got %h%h %h%h %b exp 4142 4344 1", q_lhs[1], q_rhs[1], q_lhs[2], q_rhs[2], q_last[2]);
      end
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL bp_done_pulses got %0d exp 1", done_cnt); end
  endtask

  task automatic test_swap();
    run_walk(6'd0, 1'b1, 0);
    $display("swap: beats=%0d", q_lhs.size());
    n_cmp++; if (q_lhs.size() != 3) begin n_err++; $display("FAIL swap_count got %0d exp 3", q_lhs.size()); end
    if (q_lhs.size() == 3) begin
      n_cmp++; if ({q_lhs[0], q_rhs[0]} !== 16'h3131) begin n_err++; $display("FAIL swap_beat0 got %h%h exp 3131", q_lhs[0], q_rhs[0]); end
      n_cmp++; if ({q_lhs[1], q_rhs[1]} !== 16'h4241) begin n_err++; $display("FAIL swap_beat1 got %h%h exp 4241", q_lhs[1], q_rhs[1]); end
      n_cmp++; if ({q_lhs[2], q_rhs[2], q_last[2]} !== {16'h4443, 1'b1}) begin n_err++; $display("FAIL swap_beat2 got %h%h %b exp 4443 1", q_lhs[2], q_rhs[2], q_last[2]); end
    end
  endtask

  task automatic test_zero_len();
    run_walk(6'd1, 1'b0, 0);
    $display("zero_len: valid_seen=%0d done_k=%0d addr_moved=%0d", valid_seen, done_k, addr_moved);
    n_cmp++; if (valid_seen) begin n_err++; $display("FAIL zero_valid got 1 exp 0"); end
    n_cmp++; if (done_k != 1) begin n_err++; $display("FAIL zero_done_latency got %0d exp 1", done_k); end
    n_cmp++; if (addr_moved) begin n_err++; $display("FAIL zero_addr got moved exp ff"); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL zero_done_pulses got %0d exp 1", done_cnt); end
  endtask

  task automatic test_wrap();
    run_walk(6'd2, 1'b0, 0);
    $display("wrap: beats=%0d", q_lhs.size());
    n_cmp++; if (q_lhs.size() != 2) begin n_err++; $display("FAIL wrap_count got %0d exp 2", q_lhs.size()); end
    if (q_lhs.size() == 2) begin
      n_cmp++; if ({q_addr[0], q_addr[1]} !== 16'hFF00) begin n_err++; $display("FAIL wrap_addr got %h %h exp ff 00", q_addr[0], q_addr[1]); end
      n_cmp++; if ({q_lhs[0], q_rhs[0], q_last[0]} !== {16'h5A5B, 1'b0}) begin n_err++; $display("FAIL wrap_beat0 got %h%h %b exp 5a5b 0", q_lhs[0], q_rhs[0], q_last[0]); end
      n_cmp++; if ({q_lhs[1], q_rhs[1], q_last[1]} !== {16'h3131, 1'b1}) begin n_err++; $display("FAIL wrap_beat1 got %h%h %b exp 3131 1", q_lhs[1], q_rhs[1], q_last[1]); end
    end
  endtask

  task automatic test_back_to_back();
    run_walk(6'd3, 1'b0, 0);
    // The previous walk returns on the first IDLE cycle, so this start is sampled right there.
    run_walk(6'd3, 1'b1, 0);
    $display("back_to_back: beats=%0d done_k=%0d", q_lhs.size(), done_k);
    n_cmp++; if (busy_e0 !== 1'b1) begin n_err++; $display("FAIL b2b_accept got busy=%b exp 1", busy_e0); end
    n_cmp++; if (done_k != 4) begin n_err++; $display("FAIL b2b_done_latency got %0d exp 4", done_k); end
    n_cmp++; if (q_lhs.size() != 1 || {q_lhs[0], q_rhs[0], q_last[0]} !== {16'h7877, 1'b1}) begin
      n_err++; $display("FAIL b2b_beat got n=%0d %h%h exp n=1 7877", q_lhs.size(), q_lhs[0], q_rhs[0]);
    end
  endtask

  task automatic test_reset_midwalk();
    int seen_done;
    seen_done = 0;
    stream.out_ready = 1'b0;
    start = 1'b1; line = 6'd0; swap = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 20 && !stream.out_valid; k++) begin @(posedge clk); #1; end
    start = 1'b1; line = 6'd3; swap = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stream.out_ready = 1'b1;
    @(posedge clk); #1;
    stream.out_ready = 1'b0;
    for (int k = 0; k < 20 && !stream.out_valid; k++) begin
      if (done) seen_done++;
      @(posedge clk); #1;
    end
    $display("reset_midwalk: beat2=%h%h ptr_line=%0d", stream.out_lhs, stream.out_rhs, ptr_line);
    n_cmp++; if ({stream.out_valid, stream.out_lhs, stream.out_rhs, stream.out_last} !== {1'b1, 16'h4142, 1'b0}) begin
      n_err++; $display("FAIL mid_beat2 got v=%b %h%h %b exp v=1 4142 0", stream.out_valid, stream.out_lhs, stream.out_rhs, stream.out_last);
    end
    n_cmp++; if (ptr_line !== 6'd0) begin n_err++; $display("FAIL mid_ignored_start got ptr_line=%0d exp 0", ptr_line); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({stream.out_valid, stream.out_last, busy, done} !== 4'b0000) begin n_err++; $display("FAIL mid_async_flags got %b exp 0000", {stream.out_valid, stream.out_last, busy, done}); end
    n_cmp++; if ({stream.out_lhs, stream.out_rhs, mem_addr} !== 24'h0000FF) begin n_err++; $display("FAIL mid_async_regs got %h %h exp 0000 ff", {stream.out_lhs, stream.out_rhs}, mem_addr); end
    @(posedge clk); #1;
    if (done) seen_done++;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; if (done) seen_done++; end
    n_cmp++; if (seen_done != 0) begin n_err++; $display("FAIL mid_no_done got %0d exp 0", seen_done); end
    run_walk(6'd0, 1'b0, 0);
    n_cmp++; if (q_lhs.size() != 3 || q_last[2] !== 1'b1 || {q_lhs[1], q_rhs[1]} !== 16'h4142) begin
      n_err++; $display("FAIL mid_new_walk got n=%0d exp 3 beats", q_lhs.size());
    end
    n_cmp++; if (done_k != 10 || done_cnt != 1) begin n_err++; $display("FAIL mid_new_done got k=%0d cnt=%0d exp 10 1", done_k, done_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 64; i++) ptab[i] = 14'h0000;
    mem[8'h00] = 16'h3131;
    mem[8'h01] = 16'h4142;
    mem[8'h02] = 16'h4344;
    mem[8'h20] = 16'h7778;
    mem[8'hFF] = 16'h5A5B;
    ptab[0] = {6'd3, 8'h00};
    ptab[1] = {6'd0, 8'h10};
    ptab[2] = {6'd2, 8'hFF};
    ptab[3] = {6'd1, 8'h20};

    test_reset();
    test_basic();
    test_backpressure();
    test_swap();
    test_zero_len();
    test_wrap();
    test_back_to_back();
    test_reset_midwalk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
